// File: rtl/traffic_request_arbiter_if.sv
// rtl/traffic_request_arbiter_if.sv - request/grant bundle between the phase FSM side and the arbiter
// The slave modport is the arbiter's view; master is the requester/phase-FSM view.
interface traffic_request_arbiter_if;
   logic [2:0] req;
   logic       phase_boundary;
   logic       serve_done;
   logic [2:0] grant;
   logic       grant_valid;
   logic       serving;
   logic [2:0] pending;
   logic       timeout_err;

   modport slave (
      input  req,
      input  phase_boundary,
      input  serve_done,
      output grant,
      output grant_valid,
      output serving,
      output pending,
      output timeout_err
   );

   modport master (
      output req,
      output phase_boundary,
      output serve_done,
      input  grant,
      input  grant_valid,
      input  serving,
      input  pending,
      input  timeout_err
   );
endinterface

// File: rtl/traffic_request_arbiter.sv
// rtl/traffic_request_arbiter.sv - edge-latched 3-way request arbiter with aging and serve timeout
// Requests latch on rising edges, win by age first then round-robin, and are retired by serve_done or abort.
module traffic_request_arbiter #(
   parameter int MAX_WAIT      = 64,
   parameter int SERVE_TIMEOUT = 255
) (
   input  logic                       clk,
   input  logic                       reset,
   traffic_request_arbiter_if.slave   bus
);

   localparam int AW = $clog2(MAX_WAIT + 1);
   localparam int SW = $clog2(SERVE_TIMEOUT + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_OFFER = 2'd1;
   localparam logic [1:0] ST_SERVE = 2'd2;

   localparam logic [AW-1:0] AGE_MAX = AW'(MAX_WAIT);
   localparam logic [AW-1:0] AGE_ONE = AW'(1);
   localparam logic [SW-1:0] SRV_LIM = SW'(SERVE_TIMEOUT);
   localparam logic [SW-1:0] SRV_ONE = SW'(1);

   logic [1:0]    state;
   logic [2:0]    grant_q;
   logic [2:0]    pending_q;
   logic [2:0]    prev_req;
   logic [1:0]    last_served;
   logic [SW-1:0] serve_cnt;
   logic          terr_q;

   logic [2:0]    rise;
   logic [2:0]    aged;
   logic [2:0]    clr;
   logic [2:0]    set_bits;
   logic [2:0]    winner;
   logic [1:0]    grant_idx;
   logic          in_serve;
   logic          timeout_hit;
   logic          finish;

   assign rise        = bus.req & ~prev_req;
   assign in_serve    = (state == ST_SERVE);
   assign timeout_hit = in_serve && (serve_cnt == SRV_LIM);
   assign finish      = in_serve && (bus.serve_done || timeout_hit);
   assign clr         = finish ? grant_q : 3'b000;
   // An edge only sets a bit that is idle or being retired this cycle, so a
   // re-edge on the granted bit mid-serve is dropped but one on the retire cycle sticks.
   assign set_bits    = rise & (~pending_q | clr);

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_age
         logic [AW-1:0] age;

         always_ff @(posedge clk) begin
            if (reset) begin
               age <= '0;
            end else if (clr[g] || set_bits[g]) begin
               age <= '0;
            end else if (pending_q[g] && !grant_q[g] && (age != AGE_MAX)) begin
               age <= age + AGE_ONE;
            end
         end

         assign aged[g] = pending_q[g] && (age == AGE_MAX);
      end
   endgenerate

   function automatic logic [2:0] rr_pick(input logic [2:0] p, input logic [1:0] last);
      logic [2:0] r;
      r = 3'b000;
      case (last)
         2'd0: begin
            if (p[1])      r = 3'b010;
            else if (p[2]) r = 3'b100;
            else if (p[0]) r = 3'b001;
         end
         2'd1: begin
            if (p[2])      r = 3'b100;
            else if (p[0]) r = 3'b001;
            else if (p[1]) r = 3'b010;
         end
         default: begin
            if (p[0])      r = 3'b001;
            else if (p[1]) r = 3'b010;
            else if (p[2]) r = 3'b100;
         end
      endcase
      return r;
   endfunction

   always_comb begin
      winner = 3'b000;
      if (aged[0])      winner = 3'b001;
      else if (aged[1]) winner = 3'b010;
      else if (aged[2]) winner = 3'b100;
      else              winner = rr_pick(pending_q, last_served);
   end

   always_comb begin
      grant_idx = 2'd0;
      case (grant_q)
         3'b010:  grant_idx = 2'd1;
         3'b100:  grant_idx = 2'd2;
         default: grant_idx = 2'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         grant_q     <= 3'b000;
         pending_q   <= 3'b000;
         prev_req    <= 3'b000;
         last_served <= 2'd2;
         serve_cnt   <= '0;
         terr_q      <= 1'b0;
      end else begin
         prev_req  <= bus.req;
         pending_q <= (pending_q & ~clr) | set_bits;
         case (state)
            ST_IDLE: begin
               if (|pending_q) begin
                  grant_q <= winner;
                  state   <= ST_OFFER;
               end
            end
            ST_OFFER: begin
               if (bus.phase_boundary) begin
                  state     <= ST_SERVE;
                  serve_cnt <= '0;
               end
            end
            ST_SERVE: begin
               if (finish) begin
                  state       <= ST_IDLE;
                  grant_q     <= 3'b000;
                  last_served <= grant_idx;
                  // A real completion in the abort cycle is not an error.
                  if (timeout_hit && !bus.serve_done) terr_q <= 1'b1;
               end else begin
                  serve_cnt <= serve_cnt + SRV_ONE;
               end
            end
            default: begin
               state   <= ST_IDLE;
               grant_q <= 3'b000;
            end
         endcase
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = (state == ST_OFFER) || (state == ST_SERVE);
   assign bus.serving     = in_serve;
   assign bus.pending     = pending_q;
   assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_traffic_request_arbiter.sv
// tb/tb_traffic_request_arbiter.sv - directed vector table plus corner sequences for the request arbiter
module tb_traffic_request_arbiter;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   traffic_request_arbiter_if bus();

   traffic_request_arbiter #(
      .MAX_WAIT      (4),
      .SERVE_TIMEOUT (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [2:0] req;
      logic       pb;
      logic       sd;
      logic [2:0] pend;
      logic [2:0] gnt;
      logic       gv;
      logic       srv;
      logic       terr;
   } vec_t;

   vec_t tbl [16];

   function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic p, input logic s,
                               input logic [2:0] pe, input logic [2:0] gn, input logic v,
                               input logic sv, input logic te);
      vec_t t;
      t.rst = r; t.req = rq; t.pb = p; t.sd = s;
      t.pend = pe; t.gnt = gn; t.gv = v; t.srv = sv; t.terr = te;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [2:0] rq, input logic p, input logic s);
      reset              = r;
      bus.req            = rq;
      bus.phase_boundary = p;
      bus.serve_done     = s;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] order [3];
      int n;

      clk = 1'b0;
      total = 0;
      bad = 0;
      reset = 1'b1;
      bus.req = 3'b000;
      bus.phase_boundary = 1'b0;
      bus.serve_done = 1'b0;

      // rst req pb sd | pending grant gv serving terr
      tbl[0]  = mk(1, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0);
      tbl[1]  = mk(0, 3'b010, 0, 0, 3'b010, 3'b000, 0, 0, 0);
      tbl[2]  = mk(0, 3'b000, 0, 0, 3'b010, 3'b010, 1, 0, 0);
      tbl[3]  = mk(0, 3'b000, 0, 1, 3'b010, 3'b010, 1, 0, 0);
      tbl[4]  = mk(0, 3'b000, 1, 0, 3'b010, 3'b010, 1, 1, 0);
      tbl[5]  = mk(0, 3'b000, 0, 1, 3'b000, 3'b000, 0, 0, 0);
      tbl[6]  = mk(0, 3'b000, 1, 1, 3'b000, 3'b000, 0, 0, 0);
      tbl[7]  = mk(0, 3'b101, 0, 0, 3'b101, 3'b000, 0, 0, 0);
      tbl[8]  = mk(0, 3'b101, 0, 0, 3'b101, 3'b100, 1, 0, 0);
      tbl[9]  = mk(0, 3'b101, 1, 0, 3'b101, 3'b100, 1, 1, 0);
      tbl[10] = mk(1, 3'b001, 0, 0, 3'b000, 3'b000, 0, 0, 0);
      tbl[11] = mk(0, 3'b001, 0, 0, 3'b001, 3'b000, 0, 0, 0);
      tbl[12] = mk(0, 3'b001, 0, 0, 3'b001, 3'b001, 1, 0, 0);
      tbl[13] = mk(0, 3'b001, 1, 0, 3'b001, 3'b001, 1, 1, 0);
      tbl[14] = mk(0, 3'b001, 0, 1, 3'b000, 3'b000, 0, 0, 0);
      tbl[15] = mk(0, 3'b001, 0, 0, 3'b000, 3'b000, 0, 0, 0);

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].rst, tbl[i].req, tbl[i].pb, tbl[i].sd);
         chk($sformatf("v%0d pending", i), 32'(bus.pending), 32'(tbl[i].pend));
         chk($sformatf("v%0d grant", i), 32'(bus.grant), 32'(tbl[i].gnt));
         chk($sformatf("v%0d grant_valid", i), 32'(bus.grant_valid), 32'(tbl[i].gv));
         chk($sformatf("v%0d serving", i), 32'(bus.serving), 32'(tbl[i].srv));
         chk($sformatf("v%0d timeout_err", i), 32'(bus.timeout_err), 32'(tbl[i].terr));
      end

      // Round-robin order from reset, then wrap back to bit0.
      order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
      step(1, 3'b000, 0, 0);
      step(0, 3'b111, 0, 0);
      chk("rr pending all", 32'(bus.pending), 32'h7);
      for (int k = 0; k < 3; k++) begin
         step(0, 3'b000, 0, 0);
         chk($sformatf("rr grant %0d", k), 32'(bus.grant), 32'(order[k]));
         step(0, 3'b000, 1, 0);
         step(0, 3'b000, 0, 1);
         chk($sformatf("rr idle %0d", k), 32'(bus.grant), 32'h0);
      end
      chk("rr pending drained", 32'(bus.pending), 32'h0);
      step(0, 3'b101, 0, 0);
      step(0, 3'b000, 0, 0);
      chk("rr wrap grant", 32'(bus.grant), 32'h1);

      // Aging: bit2 waits behind bit0 until aged, then beats bit1 which round-robin would pick.
      step(1, 3'b000, 0, 0);
      step(0, 3'b001, 0, 0);
      step(0, 3'b100, 0, 0);
      chk("age first grant", 32'(bus.grant), 32'h1);
      chk("age pending", 32'(bus.pending), 32'h5);
      for (int k = 0; k < 4; k++) step(0, 3'b000, 0, 0);
      chk("offer grant stable", 32'(bus.grant), 32'h1);
      step(0, 3'b000, 1, 0);
      step(0, 3'b011, 0, 1);
      chk("edge on retire cycle", 32'(bus.pending), 32'h7);
      step(0, 3'b011, 0, 0);
      chk("aged wins", 32'(bus.grant), 32'h4);

      // Forced abort after the serve timeout; the error flag is sticky.
      step(1, 3'b000, 0, 0);
      step(0, 3'b010, 0, 0);
      step(0, 3'b000, 0, 0);
      step(0, 3'b000, 1, 0);
      n = 0;
      if (bus.serving) n++;
      for (int k = 0; k < 20 && bus.serving; k++) begin
         step(0, 3'b000, 0, 0);
         if (bus.serving) n++;
      end
      chk("timeout serve cycles", 32'(n), 32'd9);
      chk("timeout err set", 32'(bus.timeout_err), 32'h1);
      chk("timeout pending cleared", 32'(bus.pending), 32'h0);
      chk("timeout grant cleared", 32'(bus.grant), 32'h0);
      step(0, 3'b001, 0, 0);
      step(0, 3'b000, 0, 0);
      chk("after timeout grant", 32'(bus.grant), 32'h1);
      chk("timeout err sticky", 32'(bus.timeout_err), 32'h1);
      step(0, 3'b000, 1, 0);
      step(0, 3'b000, 0, 1);
      chk("timeout err after serve", 32'(bus.timeout_err), 32'h1);
      step(1, 3'b000, 0, 0);
      chk("reset clears err", 32'(bus.timeout_err), 32'h0);

      // serve_done in the timeout cycle wins and leaves the flag alone.
      step(0, 3'b010, 0, 0);
      step(0, 3'b000, 0, 0);
      step(0, 3'b000, 1, 0);
      for (int k = 0; k < 8; k++) step(0, 3'b000, 0, 0);
      chk("still serving at limit", 32'(bus.serving), 32'h1);
      step(0, 3'b000, 0, 1);
      chk("tie serving", 32'(bus.serving), 32'h0);
      chk("tie no err", 32'(bus.timeout_err), 32'h0);
      chk("tie pending", 32'(bus.pending), 32'h0);

      // Held request does not re-arm; a fresh edge does.
      step(1, 3'b000, 0, 0);
      step(0, 3'b010, 0, 0);
      step(0, 3'b010, 0, 0);
      step(0, 3'b010, 1, 0);
      step(0, 3'b010, 0, 1);
      chk("held retire pending", 32'(bus.pending), 32'h0);
      step(0, 3'b010, 0, 0);
      chk("held no rearm", 32'(bus.pending), 32'h0);
      chk("held idle grant", 32'(bus.grant), 32'h0);
      step(0, 3'b000, 0, 0);
      step(0, 3'b010, 0, 0);
      chk("repulse pending", 32'(bus.pending), 32'h2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/traffic_request_arbiter.md
TRAFFIC_REQUEST_ARBITER -- requirements
Module: traffic_request_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter MAX_WAIT, default 64, meaning cycles a request may stay pending before it is flagged aged.
REQ-002 The block SHALL have parameter SERVE_TIMEOUT, default 255, meaning the maximum SERVE-state cycles before a forced abort.

Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 3 bits: active-high requests; bit0 = southbound left, bit1 = NS walk, bit2 = EW walk; already synchronous to clk.
REQ-006 The block SHALL have port phase_boundary, input, 1 bit: a 1-cycle pulse from the phase FSM when a new phase may start.
REQ-007 The block SHALL have port serve_done, input, 1 bit: a 1-cycle pulse from the phase FSM when the granted phase has completed.
REQ-008 The block SHALL have port grant, output, 3 bits: one-hot winner, or 0 when idle.
REQ-009 The block SHALL have port grant_valid, output, 1 bit: high in the OFFER and SERVE states.
REQ-010 The block SHALL have port serving, output, 1 bit: high in the SERVE state only.
REQ-011 The block SHALL have port pending, output, 3 bits: latched, not-yet-served requests.
REQ-012 The block SHALL have port timeout_err, output, 1 bit: a sticky abort flag.

Function
REQ-013 The block SHALL detect request edges: a rising edge on req[i] (0 in the previous cycle, 1 now) sets pending[i] on the next clock edge.
REQ-014 A held-high req[i] SHALL NOT re-set pending[i] after pending[i] is cleared.
REQ-015 A rising edge on req[i] SHALL be ignored while grant[i]=1 in SERVE.
REQ-016 The block SHALL have a per-request age counter, ceil(log2(MAX_WAIT+1)) bits wide.
REQ-017 The age counter SHALL be cleared to 0 when its pending bit sets.
REQ-018 The age counter SHALL increment each cycle while the request is pending and not granted, saturating at MAX_WAIT.
REQ-019 A request SHALL be "aged" when its counter equals MAX_WAIT.
REQ-020 The FSM SHALL have three states: IDLE, OFFER and SERVE.
REQ-021 In IDLE, if pending != 0, the block SHALL register the winner into grant and go to OFFER on the next edge; otherwise it stays in IDLE with grant = 0.
REQ-022 The winner SHALL be the lowest-index aged request if any request is aged.
REQ-023 Otherwise the winner SHALL be chosen round-robin: search starts at index last_served+1 mod 3 and the first pending index wins.
REQ-024 In OFFER, grant SHALL be held stable; phase_boundary=1 moves the FSM to SERVE on the next edge.
REQ-025 In OFFER, newly arriving requests SHALL NOT change grant.
REQ-026 In SERVE, serve_done=1 SHALL clear pending[winner] and its age counter, set last_served = winner, and move the FSM to IDLE on the next edge.
REQ-027 In SERVE, a serve cycle counter SHALL start at 0 on entry and increment each cycle.
REQ-028 If the serve counter reaches SERVE_TIMEOUT without serve_done, the block SHALL do the same as serve_done and also set timeout_err.
REQ-029 If serve_done arrives in the same cycle the serve counter reaches SERVE_TIMEOUT, serve_done SHALL win and timeout_err SHALL stay unchanged.
REQ-030 serve_done SHALL be ignored outside SERVE.
REQ-031 phase_boundary SHALL be ignored outside OFFER.
REQ-032 A rising edge on req[i] in the same cycle pending[i] is cleared SHALL leave pending[i] = 1.
REQ-033 Simultaneous rising edges on several bits SHALL latch all of them in the same cycle.
REQ-034 Latency SHALL be as follows: req edge to pending is 1 cycle; pending to grant_valid is 1 cycle; phase_boundary to serving is 1 cycle; serve_done to IDLE is 1 cycle.

Reset
REQ-035 When reset=1 at a clock edge, the block SHALL go to IDLE and clear grant, grant_valid, serving, pending, timeout_err, all age counters and the serve counter.
REQ-036 When reset=1 at a clock edge, the block SHALL set last_served = 2 so that bit0 has first round-robin priority, and set the previous-req register to 0.
REQ-037 Reset SHALL take priority over every other input in any state, including mid-SERVE; no grant survives reset.
REQ-038 A req held high through reset release SHALL register as a rising edge on the first cycle after release.

Verification
REQ-039 Reset then req=3'b010 pulse -> pending=010 after 1 cycle; next cycle grant=010, grant_valid=1; phase_boundary -> serving=1; serve_done -> pending=000, grant=000 one cycle later.
REQ-040 req=3'b111 together from reset -> grant order 001, 010, 100 over three full serve cycles; then a new 001+100 request -> grant 001 first (last_served=2 wraps to 0).
REQ-041 MAX_WAIT=4; bit2 pending while bit0 repeatedly re-requested and served -> once age[2]=4, grant=100 is issued ahead of pending bit0.
REQ-042 SERVE_TIMEOUT=8; enter SERVE with no serve_done -> after 8 cycles FSM returns to IDLE, pending bit cleared, timeout_err=1 and still 1 after the next grant.
REQ-043 reset asserted in SERVE with pending=101 -> next cycle all outputs 0; req held 001 through reset -> pending=001 one cycle after release.
REQ-044 Hold req[1]=1 continuously across its serve -> pending[1] stays 0 after serve_done; re-pulse 0 then 1 -> pending[1]=1.
